// File: rtl/vc_pop_scheduler_pkg.sv
// Shared encodings and defaults for the VC pop scheduler.
package vc_pop_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_VC0_TURN = 2'd1,
    ST_VC1_TURN = 2'd2,
    ST_PAUSED   = 2'd3
  } state_e;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

  localparam int DEF_WEIGHT_W    = 3;
  localparam int DEF_STALL_LIMIT = 8;
  localparam int DEF_STALL_W     = 4;

endpackage

// File: rtl/vc_pop_scheduler_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module vc_pop_scheduler_sat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up on i_inc, stick at all-ones, drop to zero on i_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))  r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/vc_pop_scheduler.sv
// Weighted pop scheduler for the VC0/VC1 FIFOs. VC0 is preferred, but after
// max(weight_vc0,1) back-to-back VC0 grants with VC1 waiting, VC1 is served.
module vc_pop_scheduler
  import vc_pop_scheduler_pkg::*;
#(
  parameter int WEIGHT_W    = DEF_WEIGHT_W,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int STALL_W     = DEF_STALL_W
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                enable,
  input  logic [WEIGHT_W-1:0] weight_vc0,
  input  logic                fifo_empty_vc0,
  input  logic                fifo_empty_vc1,
  input  logic                pausa_d0,
  input  logic                pausa_d1,
  output logic                pop_vc0,
  output logic                pop_vc1,
  output logic                valid_out,
  output logic                sel_vc,
  output logic                stall,
  output logic [1:0]          state_o
);

  state_e              r_state;
  state_e              w_next;
  logic                r_pause_q;
  logic                r_pop_vc0;
  logic                r_pop_vc1;
  logic                r_valid;
  logic                r_sel;
  logic                w_work;
  logic [WEIGHT_W-1:0] w_weight_eff;
  logic [WEIGHT_W-1:0] w_credit;
  logic [STALL_W-1:0]  w_stall_cnt;

  assign w_work       = ~fifo_empty_vc0 | ~fifo_empty_vc1;
  assign w_weight_eff = (weight_vc0 == '0) ? WEIGHT_W'(1) : weight_vc0;

  // Next-state decision on current flags; the pops are a registered image of it,
  // so a pop is only ever issued from a state chosen while that FIFO was non-empty.
  always_comb begin
    w_next = ST_VC0_TURN;
    if (!enable || !w_work)
      w_next = ST_IDLE;
    else if (r_pause_q)
      w_next = ST_PAUSED;
    else if (!fifo_empty_vc1 && (fifo_empty_vc0 || (w_credit >= w_weight_eff)))
      w_next = ST_VC1_TURN;
  end

  // FSM state, registered pops and the one-cycle-later mux valid/select.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state   <= ST_IDLE;
      r_pop_vc0 <= 1'b0;
      r_pop_vc1 <= 1'b0;
      r_valid   <= 1'b0;
      r_sel     <= VC0;
    end else begin
      r_state   <= w_next;
      r_pop_vc0 <= (w_next == ST_VC0_TURN);
      r_pop_vc1 <= (w_next == ST_VC1_TURN);
      r_valid   <= r_pop_vc0 | r_pop_vc1;
      r_sel     <= r_pop_vc1 ? VC1 : VC0;
    end
  end

  // Destination pause is registered once; all decisions use the registered copy.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_pause_q <= 1'b0;
    else          r_pause_q <= pausa_d0 | pausa_d1;
  end

  // Credit counts VC0 grants issued while VC1 waits; it updates on the same edge
  // as the pop register so the count always equals the VC0 pops already issued.
  vc_pop_scheduler_sat_counter #(.W(WEIGHT_W)) u_credit (
    .clk   (clk),
    .rst_n (reset_L),
    .i_inc ((w_next == ST_VC0_TURN) & ~fifo_empty_vc1),
    .i_clr ((w_next == ST_VC1_TURN) | fifo_empty_vc1),
    .o_cnt (w_credit)
  );

  // Stall counter tracks how long we have sat in PAUSED; it clears on leaving.
  vc_pop_scheduler_sat_counter #(.W(STALL_W)) u_stall (
    .clk   (clk),
    .rst_n (reset_L),
    .i_inc ((w_next == ST_PAUSED) & enable),
    .i_clr (w_next != ST_PAUSED),
    .o_cnt (w_stall_cnt)
  );

  assign pop_vc0   = r_pop_vc0;
  assign pop_vc1   = r_pop_vc1;
  assign valid_out = r_valid;
  assign sel_vc    = r_sel;
  assign stall     = (w_stall_cnt >= STALL_W'(STALL_LIMIT));
  assign state_o   = r_state;

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Directed bench for vc_pop_scheduler: a cycle table with hand-computed outputs,
// then FIFO-backed sequences for the weighted pop patterns and reset/enable cases.
module tb_vc_pop_scheduler;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       enable;
  logic [2:0] weight_vc0;
  logic       fifo_empty_vc0, fifo_empty_vc1;
  logic       pausa_d0, pausa_d1;
  logic       pop_vc0, pop_vc1, valid_out, sel_vc, stall;
  logic [1:0] state_o;

  int n_vec = 0;
  int n_bad = 0;
  int cnt0  = 0;
  int cnt1  = 0;

  typedef struct packed {
    logic       en;
    logic [2:0] w;
    logic       e0, e1, p0, p1;
    logic [1:0] st;
    logic       o0, o1, v, s, stl;
  } vec_t;

  vec_t tbl [32];

  vc_pop_scheduler #(.WEIGHT_W(3), .STALL_LIMIT(8), .STALL_W(4)) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .enable         (enable),
    .weight_vc0     (weight_vc0),
    .fifo_empty_vc0 (fifo_empty_vc0),
    .fifo_empty_vc1 (fifo_empty_vc1),
    .pausa_d0       (pausa_d0),
    .pausa_d1       (pausa_d1),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .valid_out      (valid_out),
    .sel_vc         (sel_vc),
    .stall          (stall),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit en, int w, bit e0, bit e1, bit p0, bit p1,
                              int st, bit o0, bit o1, bit v, bit s, bit stl);
    vec_t t;
    t.en = en; t.w = 3'(w); t.e0 = e0; t.e1 = e1; t.p0 = p0; t.p1 = p1;
    t.st = 2'(st); t.o0 = o0; t.o1 = o1; t.v = v; t.s = s; t.stl = stl;
    return t;
  endfunction

  function automatic logic [6:0] outs();
    return {state_o, pop_vc0, pop_vc1, valid_out, sel_vc, stall};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st,p0,p1,vld,sel,stall=%b expected %b", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    #1 check("reset", outs(), 7'b0);
    @(posedge clk); #1;
    reset_L = 1'b1;
  endtask

  task automatic load(input int c0, input int c1);
    cnt0 = c0; cnt1 = c1;
    fifo_empty_vc0 = (cnt0 == 0);
    fifo_empty_vc1 = (cnt1 == 0);
  endtask

  // FIFO model: a pop removes the head in the cycle it is asserted, so the
  // emptiness flag seen at the next edge already reflects it.
  task automatic fifo_tick(input string name);
    if (pop_vc0) begin
      n_vec++;
      if (cnt0 == 0) begin n_bad++; $display("FAIL %s: pop_vc0 on empty VC0 got 1 expected 0", name); end
      else cnt0--;
    end
    if (pop_vc1) begin
      n_vec++;
      if (cnt1 == 0) begin n_bad++; $display("FAIL %s: pop_vc1 on empty VC1 got 1 expected 0", name); end
      else cnt1--;
    end
    fifo_empty_vc0 = (cnt0 == 0);
    fifo_empty_vc1 = (cnt1 == 0);
  endtask

  // codes: 0 = no pop (IDLE), 1 = pop VC0, 2 = pop VC1, one per cycle.
  task automatic run_seq(input string name, input int codes[$]);
    int prev = 0;
    logic [6:0] exp;
    foreach (codes[i]) begin
      @(posedge clk); #1;
      exp = {2'(codes[i]), codes[i] == 1, codes[i] == 2, prev != 0, prev == 2, 1'b0};
      check($sformatf("%s[%0d]", name, i), outs(), exp);
      fifo_tick(name);
      prev = codes[i];
    end
  endtask

  initial begin
    int q[$];
    enable = 1'b0; weight_vc0 = 3'd2;
    fifo_empty_vc0 = 1'b1; fifo_empty_vc1 = 1'b1;
    pausa_d0 = 1'b0; pausa_d1 = 1'b0;

    //            en w e0 e1 p0 p1  st o0 o1 v s stl
    tbl[0]  = mk(0, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 2, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 2, 0, 0, 0, 0,  1, 1, 0, 1, 0, 0);
    tbl[3]  = mk(1, 2, 0, 0, 0, 0,  2, 0, 1, 1, 0, 0);
    tbl[4]  = mk(1, 2, 0, 0, 0, 0,  1, 1, 0, 1, 1, 0);
    tbl[5]  = mk(1, 2, 0, 1, 0, 0,  1, 1, 0, 1, 0, 0);
    tbl[6]  = mk(1, 2, 1, 0, 0, 0,  2, 0, 1, 1, 0, 0);
    tbl[7]  = mk(1, 2, 1, 1, 0, 0,  0, 0, 0, 1, 1, 0);
    tbl[8]  = mk(1, 2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 2, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[11] = mk(0, 2, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0,  1, 1, 0, 1, 1, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0,  2, 0, 1, 1, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 1,  1, 1, 0, 1, 1, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 1,  3, 0, 0, 1, 0, 0);
    for (int i = 17; i <= 22; i++)
      tbl[i] = mk(1, 0, 0, 0, 0, 1,  3, 0, 0, 0, 0, 0);
    tbl[23] = mk(1, 0, 0, 0, 0, 1,  3, 0, 0, 0, 0, 1);
    tbl[24] = mk(1, 0, 0, 0, 0, 1,  3, 0, 0, 0, 0, 1);
    tbl[25] = mk(1, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 1);
    tbl[26] = mk(1, 0, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0);
    tbl[27] = mk(1, 0, 0, 0, 1, 0,  1, 1, 0, 1, 1, 0);
    tbl[28] = mk(1, 0, 0, 0, 1, 0,  3, 0, 0, 1, 0, 0);
    tbl[29] = mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
    tbl[30] = mk(1, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
    tbl[31] = mk(1, 0, 0, 0, 0, 0,  2, 0, 1, 0, 0, 0);

    do_reset();

    foreach (tbl[i]) begin
      enable = tbl[i].en; weight_vc0 = tbl[i].w;
      fifo_empty_vc0 = tbl[i].e0; fifo_empty_vc1 = tbl[i].e1;
      pausa_d0 = tbl[i].p0; pausa_d1 = tbl[i].p1;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].st, tbl[i].o0, tbl[i].o1, tbl[i].v, tbl[i].s, tbl[i].stl});
    end

    // Reset asserted mid-pop: outputs drop without waiting for a clock edge.
    enable = 1'b1; weight_vc0 = 3'd3;
    fifo_empty_vc0 = 1'b0; fifo_empty_vc1 = 1'b0;
    pausa_d0 = 1'b0; pausa_d1 = 1'b0;
    #3 reset_L = 1'b0;
    #1 check("async_reset", outs(), 7'b0);
    #2 reset_L = 1'b1;
    @(posedge clk); #1;
    check("post_reset_pop", outs(), {2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    // weight 3: VC0 x3 then VC1 until VC0 drains, then VC1 alone.
    do_reset();
    weight_vc0 = 3'd3; enable = 1'b1; load(8, 8);
    q = '{1,1,1,2,1,1,1,2,1,1,2,2,2,2,2,2,0,0};
    run_seq("w3", q);

    // weight 0 behaves as 1: strict alternation.
    do_reset();
    weight_vc0 = 3'd0; load(4, 4);
    q = '{1,2,1,2,1,2,1,2,0};
    run_seq("w0", q);

    // VC0 empty: VC1 drains back-to-back, never a VC0 pop.
    do_reset();
    weight_vc0 = 3'd3; load(0, 4);
    q = '{2,2,2,2,0,0};
    run_seq("vc1_only", q);

    // Enable low with full FIFOs: nothing moves until enable rises.
    do_reset();
    enable = 1'b0; load(8, 8);
    q = '{0,0,0};
    run_seq("disabled", q);
    enable = 1'b1;
    q = '{1};
    run_seq("enable_rise", q);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
